// File: rtl/perf_pkg.sv
// Shared types and constants for the performance counter bank.
package perf_pkg;

  // Width of the shadow-register read index.
  localparam int RD_IDX_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } perf_state_t;

endpackage : perf_pkg

// File: rtl/perf_counter.sv
// Single event counter: increment, synchronous clear, wrap or saturate,
// with a one-cycle overflow pulse when an increment hits the all-ones value.
module perf_counter #(
  parameter int WIDTH    = 32,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_count,
  output logic             o_ovf
);

  logic [WIDTH-1:0] count_d, count_q;

  // Next count: clear beats increment; at all-ones an increment wraps or holds.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    o_ovf   = 1'b0;
    if (i_clear) begin
      count_d = '0;
    end else if (i_inc) begin
      if (&count_q) begin
        o_ovf   = 1'b1;
        count_d = (SATURATE != 0) ? count_q : '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values.
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign o_count = count_q;

endmodule : perf_counter

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CNT event counters with a run/idle/frozen controller,
// sticky overflow flags, a snapshot shadow array and a 1-cycle read port.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CNT       = 8,
  parameter int CNT_WIDTH     = 32,
  parameter int SATURATE      = 0,
  parameter int FREEZE_ON_OVF = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CNT-1:0]   i_event,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic                 i_clear,
  input  logic                 i_snapshot,
  input  logic                 i_rd_req,
  input  logic [RD_IDX_W-1:0]  i_rd_idx,
  output logic                 o_rd_valid,
  output logic [CNT_WIDTH-1:0] o_rd_data,
  output logic                 o_rd_err,
  output logic [NUM_CNT-1:0]   o_ovf,
  output logic [1:0]           o_state
);

  perf_state_t          state_d, state_q;
  logic                 count_en;
  logic [NUM_CNT-1:0]   ovf_pulse;
  logic [NUM_CNT-1:0]   ovf_d, ovf_q;
  logic [CNT_WIDTH-1:0] live     [NUM_CNT];
  logic [CNT_WIDTH-1:0] shadow_d [NUM_CNT];
  logic [CNT_WIDTH-1:0] shadow_q [NUM_CNT];
  logic [CNT_WIDTH-1:0] rd_sel;
  logic                 rd_in_range;
  logic                 rd_valid_d, rd_valid_q;
  logic                 rd_err_d, rd_err_q;
  logic [CNT_WIDTH-1:0] rd_data_d, rd_data_q;

  // Events only count while running; a start in the same cycle counts from the next.
  assign count_en = (state_q == RUN);

  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
    perf_counter #(
      .WIDTH    (CNT_WIDTH),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (count_en & i_event[k]),
      .i_clear (i_clear),
      .o_count (live[k]),
      .o_ovf   (ovf_pulse[k])
    );
  end

  // Controller next state: stop beats start; overflow freezes the bank when enabled.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start && !i_stop) state_d = RUN;
      RUN: begin
        if (i_stop)                                    state_d = IDLE;
        else if ((FREEZE_ON_OVF != 0) && |ovf_pulse)   state_d = FROZEN;
      end
      FROZEN:  if (i_clear || i_stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sticky flags, snapshot capture of pre-update values, and registered read.
  always_comb begin
    ovf_d = i_clear ? '0 : (ovf_q | ovf_pulse);
    for (int k = 0; k < NUM_CNT; k++) begin
      shadow_d[k] = i_snapshot ? live[k] : shadow_q[k];
    end
    rd_sel = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (i_rd_idx == RD_IDX_W'(k)) rd_sel = shadow_q[k];
    end
    rd_in_range = ({1'b0, i_rd_idx} < (RD_IDX_W + 1)'(NUM_CNT));
    rd_valid_d  = i_rd_req;
    rd_err_d    = i_rd_req && !rd_in_range;
    rd_data_d   = (i_rd_req && rd_in_range) ? rd_sel : '0;
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Flags, shadow array and read-port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q      <= '0;
      // NOTE: the shadow array is a register file that must read 0 after reset, so it is reset too.
      for (int k = 0; k < NUM_CNT; k++) shadow_q[k] <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      ovf_q      <= ovf_d;
      for (int k = 0; k < NUM_CNT; k++) shadow_q[k] <= shadow_d[k];
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign o_state    = state_q;
  assign o_ovf      = ovf_q;
  assign o_rd_valid = rd_valid_q;
  assign o_rd_err   = rd_err_q;
  assign o_rd_data  = rd_data_q;

endmodule : perf_counter_bank
